decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Instruction decode / register-read pipeline stage of the Venus core; sits directly upstream of the execute stage.
- Splits a fetched 32-bit instruction into fields and drives the register-file read ports.
- Builds the one-hot class controls and extended immediate, and registers everything into the decode/execute pipeline register.
- Detects load-use hazards, inserts bubbles, and propagates stall upstream.

Parameters:
- XLEN, 32, datapath width (register values, immediate)
- RADDR, 5, register address width (32 registers, r0 hardwired zero)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active high
- inst_i  in  XLEN  fetched instruction
- inst_valid_i  in  1  inst_i holds a real instruction
- stall_i  in  1  downstream (execute) cannot accept; hold pipeline register
- flush_i  in  1  kill the instruction currently being decoded (branch taken)
- rf_rd_addr_o  out  RADDR  register-file read address A = inst_i[25:21], combinational
- rf_rs_addr_o  out  RADDR  register-file read address B = inst_i[20:16], combinational
- rf_rd_data_i  in  XLEN  read data A, same cycle
- rf_rs_data_i  in  XLEN  read data B, same cycle
- rd_value_o  out  XLEN  registered rd operand to execute
- rs_value_o  out  XLEN  registered rs operand to execute
- imm_value_o  out  XLEN  registered extended immediate
- immf_o  out  1  immediate-operand flag
- ctrl_inte_o, ctrl_logic_o, ctrl_shift_o, ctrl_ld_o, ctrl_st_o, ctrl_br_o  out  1 each  one-hot class controls
- alu_op_o  out  3  sub-operation, inst[28:26]
- rd_addr_o  out  RADDR  destination address of the registered instruction
- valid_o  out  1  pipeline register holds a live instruction
- illegal_o  out  1  one-cycle pulse: an undefined class was decoded
- stall_o  out  1  upstream must hold inst_i, combinational

Behaviour:
- Instruction fields:
  - op = [31:26]; class = op[5:3]; rd = [25:21]; rs = [20:16]; immf = [15]; imm15 = [14:0].
- Class decode:
  - 000 inte, 001 logic, 010 shift, 011 ld, 100 st, 101 br.
  - 110 and 111 are illegal: the instruction becomes a bubble and illegal_o = 1 for one cycle.
- Immediate:
  - logic class: zero-extend imm15 to XLEN.
  - All other classes: sign-extend from bit 14.
- Operand read:
  - An address of 0 yields value 0 regardless of rf data.
- Reset (asynchronous, rst=1): every registered output is 0. That is valid_o, all ctrl_*, immf_o, illegal_o, rd_addr_o, alu_op_o, and all three values. Reset mid-stall also clears everything.
- Hazard detection:
  - hazard = inst_valid_i & valid_o & ctrl_ld_o & (rd_addr_o != 0) & (rd_addr_o == rd | rd_addr_o == rs).
  - The rd field counts as a source because execute consumes rd_value.
- stall_o = stall_i | (hazard & ~flush_i).
- Register update on rising edge, in priority order:
  1. flush_i: load a bubble, even if stall_i = 1.
  2. stall_i: hold all outputs; illegal_o is forced to 0.
  3. hazard: load a bubble; upstream holds, so the instruction is re-decoded next cycle (latency +1).
  4. Otherwise: load the decoded instruction, with valid_o = inst_valid_i & ~illegal.
- Bubble: valid_o = 0, all ctrl_* = 0, illegal_o = 0. Value fields are don't-care and are driven 0.
- Latency: decode-to-execute is 1 cycle, and 2 cycles on a load-use hazard.
- ctrl_* is never nonzero while valid_o = 0.
- inst_valid_i = 0 loads a bubble; that input has no hazard and raises no illegal_o.
- rf addresses are driven from inst_i even when inst_valid_i = 0. Reads have no side effects.

Decomposition:
- Package venus_pkg holds:
  - class encodings (CLS_INTE … CLS_BR);
  - field bit positions and imm width;
  - XLEN/RADDR defaults.
- One sub-module, decode_ctrl (combinational): inst -> one-hot ctrl, alu_op, illegal, extended imm.
- decode_stage keeps the pipeline register, hazard logic and stall/flush priority.

Test Plan:
1. Reset: assert rst mid-run with valid_o = 1 -> all outputs 0 immediately (asynchronous); they stay 0 until the first valid instruction after deassert.
2. Immediate extension:
   - inte with rd = 3, rs = 4, immf = 1, imm15 = 0x7FFF; rf returns A = 0x11, B = 0x22 -> next cycle ctrl_inte_o = 1, rd_value_o = 0x11, rs_value_o = 0x22, imm_value_o = 0xFFFFFFFF, valid_o = 1.
   - Same instruction as logic class -> imm_value_o = 0x00007FFF.
3. Load-use, then no hazard:
   - ld to r5, followed by an inte with rs = 5 -> stall_o = 1 for one cycle and a bubble (valid_o = 0) that cycle; the inte appears one cycle later.
   - ld to r0 followed by rs = 0 -> no stall.
4. Stall hold: stall_i = 1 for 3 cycles with the pipeline register holding st -> all outputs unchanged and stall_o = 1 throughout; the next instruction loads on the first cycle after release.
5. Flush over stall: flush_i = 1 together with stall_i = 1 while a br is held -> next cycle valid_o = 0 and all ctrl_* = 0.
6. Illegal: class 110 decoded -> illegal_o pulses for exactly one cycle with valid_o = 0 and all ctrl_* = 0.

Source files
------------

// File: rtl/venus_pkg.sv
// Shared definitions for the Venus decode path: default widths, instruction
// field positions and the instruction class encodings.
package venus_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int RADDR_DEF = 5;

  localparam int CLS_MSB  = 31;
  localparam int ALU_LSB  = 26;
  localparam int RD_MSB   = 25;
  localparam int RD_LSB   = 21;
  localparam int RS_MSB   = 20;
  localparam int RS_LSB   = 16;
  localparam int IMMF_BIT = 15;
  localparam int IMM_W    = 15;

  typedef enum logic [2:0] {
    CLS_INTE  = 3'b000,
    CLS_LOGIC = 3'b001,
    CLS_SHIFT = 3'b010,
    CLS_LD    = 3'b011,
    CLS_ST    = 3'b100,
    CLS_BR    = 3'b101
  } cls_e;

  typedef struct packed {
    logic inte;
    logic lgc;
    logic shift;
    logic ld;
    logic st;
    logic br;
  } ctrl_t;

endpackage

// File: rtl/decode_ctrl.sv
// Combinational opcode decode: one-hot class controls, ALU sub-op, illegal
// class flag and the extended immediate.
module decode_ctrl
  import venus_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [5:0]       op,
  input  logic [IMM_W-1:0] imm15,
  output ctrl_t            ctrl,
  output logic [2:0]       alu_op,
  output logic             illegal,
  output logic [XLEN-1:0]  imm
);

  logic [2:0] cls;

  assign cls    = op[5:3];
  assign alu_op = op[2:0];

  always_comb begin
    ctrl    = '0;
    illegal = 1'b0;
    case (cls)
      CLS_INTE:  ctrl.inte  = 1'b1;
      CLS_LOGIC: ctrl.lgc   = 1'b1;
      CLS_SHIFT: ctrl.shift = 1'b1;
      CLS_LD:    ctrl.ld    = 1'b1;
      CLS_ST:    ctrl.st    = 1'b1;
      CLS_BR:    ctrl.br    = 1'b1;
      default:   illegal    = 1'b1;
    endcase
  end

  // Logical operations want raw bit masks, so only they zero-extend.
  assign imm = (cls == CLS_LOGIC) ? {{(XLEN-IMM_W){1'b0}}, imm15}
                                  : {{(XLEN-IMM_W){imm15[IMM_W-1]}}, imm15};

endmodule

// File: rtl/decode_stage.sv
// Venus decode / register-read stage: drives the register-file read ports and
// owns the decode/execute pipeline register with load-use and stall handling.
module decode_stage
  import venus_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int RADDR = RADDR_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  inst_i,
  input  logic             inst_valid_i,
  input  logic             stall_i,
  input  logic             flush_i,
  output logic [RADDR-1:0] rf_rd_addr_o,
  output logic [RADDR-1:0] rf_rs_addr_o,
  input  logic [XLEN-1:0]  rf_rd_data_i,
  input  logic [XLEN-1:0]  rf_rs_data_i,
  output logic [XLEN-1:0]  rd_value_o,
  output logic [XLEN-1:0]  rs_value_o,
  output logic [XLEN-1:0]  imm_value_o,
  output logic             immf_o,
  output logic             ctrl_inte_o,
  output logic             ctrl_logic_o,
  output logic             ctrl_shift_o,
  output logic             ctrl_ld_o,
  output logic             ctrl_st_o,
  output logic             ctrl_br_o,
  output logic [2:0]       alu_op_o,
  output logic [RADDR-1:0] rd_addr_o,
  output logic             valid_o,
  output logic             illegal_o,
  output logic             stall_o
);

  typedef struct packed {
    logic             valid;
    ctrl_t            ctrl;
    logic             illegal;
    logic             immf;
    logic [2:0]       alu_op;
    logic [RADDR-1:0] rd_addr;
    logic [XLEN-1:0]  rd_value;
    logic [XLEN-1:0]  rs_value;
    logic [XLEN-1:0]  imm_value;
  } dx_t;

  dx_t              dx_q;
  dx_t              dx_d;
  dx_t              dec;
  logic [RADDR-1:0] rd_f;
  logic [RADDR-1:0] rs_f;
  ctrl_t            dec_ctrl;
  logic [2:0]       dec_alu;
  logic             dec_illegal;
  logic [XLEN-1:0]  dec_imm;
  logic             hazard;
  logic             live;

  assign rd_f         = inst_i[RD_MSB:RD_LSB];
  assign rs_f         = inst_i[RS_MSB:RS_LSB];
  assign rf_rd_addr_o = rd_f;
  assign rf_rs_addr_o = rs_f;

  decode_ctrl #(.XLEN(XLEN)) u_decode_ctrl (
    .op      (inst_i[CLS_MSB:ALU_LSB]),
    .imm15   (inst_i[IMM_W-1:0]),
    .ctrl    (dec_ctrl),
    .alu_op  (dec_alu),
    .illegal (dec_illegal),
    .imm     (dec_imm)
  );

  // rd is a source too: execute consumes rd_value, so it must wait for the load.
  assign hazard = inst_valid_i & dx_q.valid & dx_q.ctrl.ld & (dx_q.rd_addr != '0) &
                  ((dx_q.rd_addr == rd_f) | (dx_q.rd_addr == rs_f));
  assign stall_o = stall_i | (hazard & ~flush_i);
  assign live    = inst_valid_i & ~dec_illegal;

  always_comb begin
    dec         = '0;
    dec.illegal = inst_valid_i & dec_illegal;
    if (live) begin
      dec.valid     = 1'b1;
      dec.ctrl      = dec_ctrl;
      dec.immf      = inst_i[IMMF_BIT];
      dec.alu_op    = dec_alu;
      dec.rd_addr   = rd_f;
      dec.rd_value  = (rd_f == '0) ? '0 : rf_rd_data_i;
      dec.rs_value  = (rs_f == '0) ? '0 : rf_rs_data_i;
      dec.imm_value = dec_imm;
    end
  end

  // A held instruction must not re-report illegal while execute is stalled.
  always_comb begin
    dx_d = dx_q;
    if (flush_i) begin
      dx_d = '0;
    end else if (stall_i) begin
      dx_d.illegal = 1'b0;
    end else if (hazard) begin
      dx_d = '0;
    end else begin
      dx_d = dec;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dx_q <= '0;
    end else begin
      dx_q <= dx_d;
    end
  end

  assign valid_o      = dx_q.valid;
  assign ctrl_inte_o  = dx_q.ctrl.inte;
  assign ctrl_logic_o = dx_q.ctrl.lgc;
  assign ctrl_shift_o = dx_q.ctrl.shift;
  assign ctrl_ld_o    = dx_q.ctrl.ld;
  assign ctrl_st_o    = dx_q.ctrl.st;
  assign ctrl_br_o    = dx_q.ctrl.br;
  assign illegal_o    = dx_q.illegal;
  assign immf_o       = dx_q.immf;
  assign alu_op_o     = dx_q.alu_op;
  assign rd_addr_o    = dx_q.rd_addr;
  assign rd_value_o   = dx_q.rd_value;
  assign rs_value_o   = dx_q.rs_value;
  assign imm_value_o  = dx_q.imm_value;

endmodule

// File: tb/tb_decode_stage.sv
// Directed scenarios plus randomized traffic checked against a behavioural
// model of the decode stage built from the instruction-format rules.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_i;
  logic        inst_valid_i, stall_i, flush_i;
  logic [4:0]  rf_rd_addr_o, rf_rs_addr_o;
  logic [31:0] rf_rd_data_i, rf_rs_data_i;
  logic [31:0] rd_value_o, rs_value_o, imm_value_o;
  logic        immf_o, valid_o, illegal_o, stall_o;
  logic        ctrl_inte_o, ctrl_logic_o, ctrl_shift_o, ctrl_ld_o, ctrl_st_o, ctrl_br_o;
  logic [2:0]  alu_op_o;
  logic [4:0]  rd_addr_o;

  logic [31:0] rf_mem [32];
  logic [5:0]  ctrl_vec;
  logic [112:0] snap;
  int checks = 0;
  int errors = 0;

  logic        m_valid, m_ill, m_immf;
  logic [5:0]  m_ctrl;
  logic [2:0]  m_alu;
  logic [4:0]  m_rda;
  logic [31:0] m_rdv, m_rsv, m_imm;

  always #5 clk = ~clk;

  assign rf_rd_data_i = rf_mem[rf_rd_addr_o];
  assign rf_rs_data_i = rf_mem[rf_rs_addr_o];
  assign ctrl_vec = {ctrl_br_o, ctrl_st_o, ctrl_ld_o, ctrl_shift_o, ctrl_logic_o, ctrl_inte_o};
  assign snap = {valid_o, ctrl_vec, illegal_o, immf_o, alu_op_o, rd_addr_o,
                 rd_value_o, rs_value_o, imm_value_o};

  decode_stage dut (
    .clk(clk), .rst(rst), .inst_i(inst_i), .inst_valid_i(inst_valid_i),
    .stall_i(stall_i), .flush_i(flush_i),
    .rf_rd_addr_o(rf_rd_addr_o), .rf_rs_addr_o(rf_rs_addr_o),
    .rf_rd_data_i(rf_rd_data_i), .rf_rs_data_i(rf_rs_data_i),
    .rd_value_o(rd_value_o), .rs_value_o(rs_value_o), .imm_value_o(imm_value_o),
    .immf_o(immf_o), .ctrl_inte_o(ctrl_inte_o), .ctrl_logic_o(ctrl_logic_o),
    .ctrl_shift_o(ctrl_shift_o), .ctrl_ld_o(ctrl_ld_o), .ctrl_st_o(ctrl_st_o),
    .ctrl_br_o(ctrl_br_o), .alu_op_o(alu_op_o), .rd_addr_o(rd_addr_o),
    .valid_o(valid_o), .illegal_o(illegal_o), .stall_o(stall_o)
  );

  function automatic logic [31:0] mk_inst(input logic [2:0] cls, input logic [2:0] alu,
                                          input logic [4:0] rd, input logic [4:0] rs,
                                          input logic immf, input logic [14:0] imm);
    return {cls, alu, rd, rs, immf, imm};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] inst, input logic iv, input logic st, input logic fl);
    inst_i       = inst;
    inst_valid_i = iv;
    stall_i      = st;
    flush_i      = fl;
    #1;
  endtask

  task automatic model_clear();
    m_valid = 0; m_ctrl = 0; m_ill = 0; m_immf = 0; m_alu = 0; m_rda = 0;
    m_rdv = 0; m_rsv = 0; m_imm = 0;
  endtask

  // Predicts stall_o for the current inputs, then advances to the post-edge register contents.
  task automatic model_step(input logic [31:0] inst, input logic iv, input logic st,
                            input logic fl, output logic exp_stall);
    int cls, rd, rs, imm15;
    logic haz;
    cls   = int'(inst >> 29);
    rd    = int'((inst >> 21) % 32);
    rs    = int'((inst >> 16) % 32);
    imm15 = int'(inst % 32768);
    haz = iv && m_valid && (m_ctrl == 6'd8) && (m_rda != 0) &&
          (int'(m_rda) == rd || int'(m_rda) == rs);
    exp_stall = st || (haz && !fl);
    if (fl || (!st && haz)) begin
      model_clear();
    end else if (st) begin
      m_ill = 0;
    end else begin
      model_clear();
      if (iv && cls < 6) begin
        m_valid = 1;
        m_ctrl  = 6'(1 << cls);
        m_rda   = 5'(rd);
        m_rdv   = (rd == 0) ? 32'd0 : rf_mem[rd];
        m_rsv   = (rs == 0) ? 32'd0 : rf_mem[rs];
        m_immf  = 1'((inst >> 15) % 2);
        m_alu   = 3'((inst >> 26) % 8);
        if (cls == 1) m_imm = 32'(imm15);
        else          m_imm = (imm15 >= 16384) ? 32'(imm15 - 32768) : 32'(imm15);
      end else begin
        m_ill = iv;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(32'd0, 0, 0, 0);
    tick();
    checks++;
    if (snap !== 113'd0) begin errors++; $display("[TB] FAIL reset_initial: got %h expected 0", snap); end
    rst = 1'b0;
    drive(mk_inst(3'b000, 3'd1, 5'd1, 5'd2, 1'b0, 15'h0010), 1, 0, 0);
    tick();
    checks++;
    if (valid_o !== 1'b1) begin errors++; $display("[TB] FAIL reset_pre_valid: got %b expected 1", valid_o); end
    rst = 1'b1;
    #1;
    checks++;
    if (snap !== 113'd0) begin errors++; $display("[TB] FAIL reset_async: got %h expected 0", snap); end
    tick();
    rst = 1'b0;
    drive(mk_inst(3'b000, 3'd1, 5'd1, 5'd2, 1'b0, 15'h0010), 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (snap !== 113'd0) begin errors++; $display("[TB] FAIL reset_idle[%0d]: got %h expected 0", i, snap); end
    end
    drive(mk_inst(3'b000, 3'd1, 5'd1, 5'd2, 1'b0, 15'h0010), 1, 0, 0);
    tick();
    checks++;
    if (valid_o !== 1'b1 || ctrl_vec !== 6'b000001) begin
      errors++; $display("[TB] FAIL reset_first_inst: got valid %b ctrl %b expected 1 000001", valid_o, ctrl_vec);
    end
  endtask

  task automatic test_imm_ext();
    drive(mk_inst(3'b000, 3'd0, 5'd3, 5'd4, 1'b1, 15'h7FFF), 1, 0, 0);
    tick();
    checks++;
    if (snap !== {1'b1, 6'b000001, 1'b0, 1'b1, 3'd0, 5'd3, 32'h11, 32'h22, 32'hFFFF_FFFF}) begin
      errors++; $display("[TB] FAIL imm_inte: got %h expected %h", snap,
                         {1'b1, 6'b000001, 1'b0, 1'b1, 3'd0, 5'd3, 32'h11, 32'h22, 32'hFFFF_FFFF});
    end
    drive(mk_inst(3'b001, 3'd0, 5'd3, 5'd4, 1'b1, 15'h7FFF), 1, 0, 0);
    tick();
    checks++;
    if (imm_value_o !== 32'h0000_7FFF || ctrl_vec !== 6'b000010 || valid_o !== 1'b1) begin
      errors++; $display("[TB] FAIL imm_logic: got imm %h ctrl %b expected 00007fff 000010", imm_value_o, ctrl_vec);
    end
  endtask

  task automatic test_load_use();
    drive(mk_inst(3'b011, 3'd0, 5'd5, 5'd1, 1'b1, 15'h0004), 1, 0, 0);
    tick();
    checks++;
    if (ctrl_vec !== 6'b001000 || rd_addr_o !== 5'd5) begin
      errors++; $display("[TB] FAIL ld_load: got ctrl %b rd %0d expected 001000 5", ctrl_vec, rd_addr_o);
    end
    drive(mk_inst(3'b000, 3'd2, 5'd7, 5'd5, 1'b0, 15'h0000), 1, 0, 0);
    checks++;
    if (stall_o !== 1'b1) begin errors++; $display("[TB] FAIL ld_use_stall: got %b expected 1", stall_o); end
    tick();
    checks++;
    if (valid_o !== 1'b0 || ctrl_vec !== 6'b0) begin
      errors++; $display("[TB] FAIL ld_use_bubble: got valid %b ctrl %b expected 0 000000", valid_o, ctrl_vec);
    end
    checks++;
    if (stall_o !== 1'b0) begin errors++; $display("[TB] FAIL ld_use_release: got %b expected 0", stall_o); end
    tick();
    checks++;
    if (valid_o !== 1'b1 || ctrl_vec !== 6'b000001 || rs_value_o !== rf_mem[5] || rd_value_o !== rf_mem[7]) begin
      errors++; $display("[TB] FAIL ld_use_replay: got valid %b ctrl %b rs %h expected 1 000001 %h",
                         valid_o, ctrl_vec, rs_value_o, rf_mem[5]);
    end
    drive(mk_inst(3'b011, 3'd0, 5'd0, 5'd2, 1'b1, 15'h0000), 1, 0, 0);
    tick();
    drive(mk_inst(3'b000, 3'd0, 5'd0, 5'd0, 1'b0, 15'h0001), 1, 0, 0);
    checks++;
    if (stall_o !== 1'b0) begin errors++; $display("[TB] FAIL ld_r0_no_stall: got %b expected 0", stall_o); end
    tick();
    checks++;
    if (valid_o !== 1'b1 || ctrl_vec !== 6'b000001 || rd_value_o !== 32'd0 || rs_value_o !== 32'd0) begin
      errors++; $display("[TB] FAIL ld_r0_next: got valid %b ctrl %b rd %h rs %h expected 1 000001 0 0",
                         valid_o, ctrl_vec, rd_value_o, rs_value_o);
    end
  endtask

  task automatic test_stall_hold();
    logic [112:0] exp;
    exp = {1'b1, 6'b010000, 1'b0, 1'b0, 3'd2, 5'd9, rf_mem[9], rf_mem[10], 32'hFFFF_C001};
    drive(mk_inst(3'b100, 3'd2, 5'd9, 5'd10, 1'b0, 15'h4001), 1, 0, 0);
    tick();
    checks++;
    if (snap !== exp) begin errors++; $display("[TB] FAIL st_load: got %h expected %h", snap, exp); end
    drive(mk_inst(3'b101, 3'd3, 5'd11, 5'd12, 1'b0, 15'h0002), 1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (stall_o !== 1'b1) begin errors++; $display("[TB] FAIL stall_out[%0d]: got %b expected 1", i, stall_o); end
      tick();
      checks++;
      if (snap !== exp) begin errors++; $display("[TB] FAIL stall_hold[%0d]: got %h expected %h", i, snap, exp); end
    end
    drive(mk_inst(3'b101, 3'd3, 5'd11, 5'd12, 1'b0, 15'h0002), 1, 0, 0);
    tick();
    checks++;
    if (valid_o !== 1'b1 || ctrl_vec !== 6'b100000 || rd_addr_o !== 5'd11) begin
      errors++; $display("[TB] FAIL stall_release: got valid %b ctrl %b rd %0d expected 1 100000 11",
                         valid_o, ctrl_vec, rd_addr_o);
    end
  endtask

  task automatic test_flush_over_stall();
    drive(mk_inst(3'b000, 3'd1, 5'd13, 5'd14, 1'b0, 15'h0003), 1, 1, 1);
    tick();
    checks++;
    if (valid_o !== 1'b0 || ctrl_vec !== 6'b0 || illegal_o !== 1'b0) begin
      errors++; $display("[TB] FAIL flush_over_stall: got valid %b ctrl %b expected 0 000000", valid_o, ctrl_vec);
    end
  endtask

  task automatic test_illegal();
    drive(mk_inst(3'b110, 3'd0, 5'd1, 5'd2, 1'b0, 15'h0000), 1, 0, 0);
    tick();
    checks++;
    if (illegal_o !== 1'b1 || valid_o !== 1'b0 || ctrl_vec !== 6'b0) begin
      errors++; $display("[TB] FAIL illegal_pulse: got ill %b valid %b ctrl %b expected 1 0 000000",
                         illegal_o, valid_o, ctrl_vec);
    end
    drive(mk_inst(3'b000, 3'd0, 5'd1, 5'd2, 1'b0, 15'h0000), 1, 0, 0);
    tick();
    checks++;
    if (illegal_o !== 1'b0 || valid_o !== 1'b1) begin
      errors++; $display("[TB] FAIL illegal_clear: got ill %b valid %b expected 0 1", illegal_o, valid_o);
    end
    drive(mk_inst(3'b111, 3'd0, 5'd1, 5'd2, 1'b0, 15'h0000), 0, 0, 0);
    tick();
    checks++;
    if (illegal_o !== 1'b0 || valid_o !== 1'b0) begin
      errors++; $display("[TB] FAIL illegal_invalid: got ill %b valid %b expected 0 0", illegal_o, valid_o);
    end
  endtask

  task automatic test_random();
    logic [31:0]  inst;
    logic         iv, st, fl, exp_stall;
    logic [112:0] exp;
    logic [2:0]   cls;
    for (int i = 0; i < 32; i++) rf_mem[i] = $urandom;
    drive(32'd0, 0, 0, 0);
    rst = 1'b1;
    #1;
    rst = 1'b0;
    model_clear();
    exp_stall = 1'b0;
    inst = 32'd0;
    for (int i = 0; i < 400; i++) begin
      if (!exp_stall) begin
        cls  = ($urandom_range(0, 2) == 0) ? 3'b011 : 3'($urandom_range(0, 7));
        inst = mk_inst(cls, 3'($urandom_range(0, 7)), 5'($urandom_range(0, 4)),
                       5'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), 15'($urandom));
      end
      iv = ($urandom_range(0, 9) != 0);
      st = ($urandom_range(0, 5) == 0);
      fl = ($urandom_range(0, 9) == 0);
      drive(inst, iv, st, fl);
      model_step(inst, iv, st, fl, exp_stall);
      checks++;
      if (stall_o !== exp_stall) begin
        errors++; $display("[TB] FAIL rand_stall[%0d]: got %b expected %b", i, stall_o, exp_stall);
      end
      checks++;
      if (rf_rd_addr_o !== inst[25:21] || rf_rs_addr_o !== inst[20:16]) begin
        errors++; $display("[TB] FAIL rand_rf_addr[%0d]: got %0d/%0d expected %0d/%0d",
                           i, rf_rd_addr_o, rf_rs_addr_o, inst[25:21], inst[20:16]);
      end
      tick();
      exp = {m_valid, m_ctrl, m_ill, m_immf, m_alu, m_rda, m_rdv, m_rsv, m_imm};
      checks++;
      if (snap !== exp) begin
        errors++; $display("[TB] FAIL rand_regs[%0d]: got %h expected %h", i, snap, exp);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf_mem[i] = 32'h1000_0000 | 32'(i);
    rf_mem[3] = 32'h11;
    rf_mem[4] = 32'h22;
    test_reset();
    test_imm_ext();
    test_load_use();
    test_stall_hold();
    test_flush_over_stall();
    test_illegal();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
